// File: rtl/ste_snd_fifo.sv
// ste_snd_fifo: shifter-side sound DMA receiver. Captures 16-bit words on the
// falling edge of sload_n into a small FIFO and plays them out as signed 8-bit
// left/right samples at the selected rate, requesting more words via sreq.
// Build option: define SND_UNDERRUN_MUTE_EN to output silence (with stb) on
// an underrun tick instead of holding the last sample.
module ste_snd_fifo #(
   parameter int DEPTH    = 4,
   parameter int BASE_DIV = 640
) (
   input  logic        clk32,
   input  logic        por,
   input  logic        sndon,
   input  logic        sload_n,
   input  logic [15:0] d,
   input  logic        stereo,
   input  logic [1:0]  rate,
   output logic        sreq,
   output logic [7:0]  left,
   output logic [7:0]  right,
   output logic        stb,
   output logic        ovf,
   output logic        unf
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   // must hold BASE_DIV*8 (slowest period) without wrapping
   localparam int SW = $clog2(BASE_DIV * 8 + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [SW-1:0] BASE_C  = SW'(BASE_DIV);

   logic [15:0]   mem_q [DEPTH];
   logic          sload_q, sload_d;
   logic          sndon_q, sndon_d;
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [SW-1:0] presc_q, presc_d;
   logic          phase_q, phase_d;
   logic          sreq_q, sreq_d;
   logic [7:0]    left_q, left_d;
   logic [7:0]    right_q, right_d;
   logic          stb_q, stb_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;

   logic          load, rise, empty, full, tick, pop, push;
   logic [15:0]   rd_word;
   logic [SW-1:0] reload;

   // Next-state logic: load detect, prescaler, pop/push, sample output, flags.
   always_comb begin
      load    = sload_q & ~sload_n;
      rise    = sndon & ~sndon_q;
      empty   = (cnt_q == '0);
      full    = (cnt_q == DEPTH_C);
      tick    = sndon & (presc_q == '0);
      rd_word = mem_q[rptr_q];
      reload  = (BASE_C << (2'd3 - rate)) - SW'(1);
      // a mono word is only consumed on its second (low byte) tick
      pop     = tick & ~empty & (stereo | phase_q);
      // pop is evaluated first, so a full FIFO being drained still accepts
      push    = load & sndon & (~full | pop);

      sload_d = sload_n;
      sndon_d = sndon;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      cnt_d   = cnt_q;
      presc_d = presc_q;
      phase_d = phase_q;
      left_d  = left_q;
      right_d = right_q;
      stb_d   = 1'b0;
      ovf_d   = ovf_q;
      unf_d   = unf_q;

      if (!sndon) begin
         wptr_d  = '0;
         rptr_d  = '0;
         cnt_d   = '0;
         presc_d = reload;
         phase_d = 1'b0;
         left_d  = '0;
         right_d = '0;
      end else begin
         if (rise) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
         end
         presc_d = tick ? reload : presc_q - SW'(1);
         if (tick) begin
            if (empty) begin
               unf_d = 1'b1;
`ifdef SND_UNDERRUN_MUTE_EN
               left_d  = '0;
               right_d = '0;
               stb_d   = 1'b1;
`endif
            end else begin
               stb_d = 1'b1;
               if (stereo) begin
                  left_d  = rd_word[15:8];
                  right_d = rd_word[7:0];
               end else if (!phase_q) begin
                  left_d  = rd_word[15:8];
                  right_d = rd_word[15:8];
               end else begin
                  left_d  = rd_word[7:0];
                  right_d = rd_word[7:0];
               end
               phase_d = ~phase_q;
            end
         end
         if (stereo) phase_d = 1'b0;
         if (pop)  rptr_d = rptr_q + PW'(1);
         if (push) wptr_d = wptr_q + PW'(1);
         // sndon is high here, so a load that is not pushed hit a full FIFO
         if (load && !push) ovf_d = 1'b1;
         cnt_d = cnt_q + CW'(push) - CW'(pop);
      end
      // two free slots leave room for the load already in flight at the MCU
      sreq_d = sndon & ((DEPTH_C - cnt_d) >= CW'(2));
   end

   // FIFO storage; contents need no reset since count gates every read.
   always_ff @(posedge clk32) begin
      if (push) mem_q[wptr_q] <= d;
   end

   // State and registered outputs.
   always_ff @(posedge clk32 or posedge por) begin
      if (por) begin
         sload_q <= 1'b1;
         sndon_q <= 1'b0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         presc_q <= '0;
         phase_q <= 1'b0;
         sreq_q  <= 1'b0;
         left_q  <= '0;
         right_q <= '0;
         stb_q   <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         sload_q <= sload_d;
         sndon_q <= sndon_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
         presc_q <= presc_d;
         phase_q <= phase_d;
         sreq_q  <= sreq_d;
         left_q  <= left_d;
         right_q <= right_d;
         stb_q   <= stb_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign sreq  = sreq_q;
   assign left  = left_q;
   assign right = right_q;
   assign stb   = stb_q;
   assign ovf   = ovf_q;
   assign unf   = unf_q;

endmodule

// File: tb/tb_ste_snd_fifo.sv
// tb_ste_snd_fifo: directed scenarios plus randomized traffic, with every
// cycle's outputs compared against a queue-based reference model.
module tb_ste_snd_fifo;

   localparam int DEPTH    = 4;
   localparam int BASE_DIV = 640;

   logic        clk32 = 1'b0;
   logic        por = 1'b1;
   logic        sndon = 1'b0;
   logic        sload_n = 1'b1;
   logic [15:0] d = '0;
   logic        stereo = 1'b0;
   logic [1:0]  rate = 2'd3;
   logic        sreq, stb, ovf, unf;
   logic [7:0]  left, right;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk32 = ~clk32;

   ste_snd_fifo #(.DEPTH(DEPTH), .BASE_DIV(BASE_DIV)) dut (
      .clk32(clk32), .por(por), .sndon(sndon), .sload_n(sload_n), .d(d),
      .stereo(stereo), .rate(rate), .sreq(sreq), .left(left), .right(right),
      .stb(stb), .ovf(ovf), .unf(unf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // reference model: FIFO as a queue, tick timer as a plain countdown
   logic [15:0] mq[$];
   int          m_tcnt = 0;
   logic        m_phase = 1'b0, m_slp = 1'b1, m_snp = 1'b0;
   logic [7:0]  m_l = '0, m_r = '0;
   logic        m_stb = 1'b0, m_sreq = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;
   int          cyc = 0, stb_cnt = 0, stb_t = 0;
   bit          chk_en = 1'b0;

   function automatic int period(input logic [1:0] r);
      return BASE_DIV << (3 - int'(r));
   endfunction

   // advance the model by the clock edge that just passed
   task automatic model_step();
      logic [15:0] w;
      bit ld, tk;
      if (por) begin
         mq.delete();
         m_tcnt = 0; m_phase = 1'b0; m_slp = 1'b1; m_snp = 1'b0;
         m_l = '0; m_r = '0; m_stb = 1'b0; m_sreq = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
         return;
      end
      ld = m_slp && !sload_n;
      tk = sndon && (m_tcnt == 0);
      m_stb = 1'b0;
      if (!sndon) begin
         mq.delete();
         m_phase = 1'b0; m_l = '0; m_r = '0;
         m_tcnt = period(rate) - 1;
      end else begin
         if (!m_snp) begin m_ovf = 1'b0; m_unf = 1'b0; end
         if (tk) begin
            m_tcnt = period(rate) - 1;
            if (mq.size() == 0) begin
               m_unf = 1'b1;
`ifdef SND_UNDERRUN_MUTE_EN
               m_l = '0; m_r = '0; m_stb = 1'b1;
`endif
            end else begin
               w = mq[0];
               m_stb = 1'b1;
               if (stereo) begin m_l = w[15:8]; m_r = w[7:0]; end
               else begin m_l = m_phase ? w[7:0] : w[15:8]; m_r = m_l; end
               if (stereo || m_phase) void'(mq.pop_front());
               m_phase = !m_phase;
            end
         end else begin
            m_tcnt--;
         end
         if (stereo) m_phase = 1'b0;
         if (ld) begin
            if (mq.size() < DEPTH) mq.push_back(d);
            else m_ovf = 1'b1;
         end
      end
      m_sreq = sndon && ((DEPTH - mq.size()) >= 2);
      m_slp = sload_n;
      m_snp = sndon;
   endtask

   // inputs change at negedge+1, so at negedge they still hold the values
   // the DUT saw at the preceding posedge
   initial forever begin
      @(negedge clk32);
      cyc++;
      model_step();
      if (stb === 1'b1) begin stb_cnt++; stb_t = cyc; end
      if (chk_en)
         chk("outs", {12'h0, sreq, stb, ovf, unf, left, right},
                     {12'h0, m_sreq, m_stb, m_ovf, m_unf, m_l, m_r});
   end

   task automatic nxt(input int n = 1);
      repeat (n) begin @(negedge clk32); #1; end
   endtask

   task automatic load_word(input logic [15:0] w);
      d = w; sload_n = 1'b0; nxt();
      sload_n = 1'b1; nxt();
   endtask

   task automatic wait_stb(input string tag, output int t);
      int c0, n;
      c0 = stb_cnt; n = 0;
      while (stb_cnt == c0 && n < 12000) begin nxt(); n++; end
      chk(tag, 32'(stb_cnt != c0), 1);
      t = stb_t;
   endtask

   initial begin
      int t0, t1, n, lp;
      nxt(3);
      chk("rst_outs", {12'h0, sreq, stb, ovf, unf, left, right}, 32'h0);
      chk_en = 1'b1;

      // reset in the middle of a stream
      stereo = 1'b1; rate = 2'd3; sndon = 1'b1; nxt();
      load_word(16'hA1A2); load_word(16'hB1B2); load_word(16'hC1C2);
      por = 1'b1; nxt();
      chk("por_outs", {12'h0, sreq, stb, ovf, unf, left, right}, 32'h0);
      por = 1'b0; nxt();
      chk("por_sreq", sreq, 1);

      // stereo at the fastest rate
      load_word(16'h7F80);
      wait_stb("st_stb1", t0);
      chk("st_lr", {left, right}, 16'h7F80);
      nxt();
      chk("st_stb_pulse", stb, 0);
      load_word(16'h0102);
      wait_stb("st_stb2", t1);
      chk("st_period", 32'(t1 - t0), 640);

      // mono at the slowest rate
      stereo = 1'b0; rate = 2'd0;
      load_word(16'h1234);
      wait_stb("mo_stb1", t0);
      chk("mo_hi", {left, right}, 16'h1212);
      wait_stb("mo_stb2", t1);
      chk("mo_lo", {left, right}, 16'h3434);
      chk("mo_period", 32'(t1 - t0), 5120);

      // flush, then flow control and overflow
      rate = 2'd3; stereo = 1'b1; sndon = 1'b0; nxt(2);
      chk("off_outs", {15'h0, sreq, left, right}, 32'h0);
      sndon = 1'b1; nxt();
      chk("on_flags", {30'h0, ovf, unf}, 32'h0);
      load_word(16'h0001); load_word(16'h0002);
      chk("fc_sreq2", sreq, 1);
      load_word(16'h0003);
      chk("fc_sreq3", sreq, 0);
      load_word(16'h0004);
      chk("fc_ovf4", ovf, 0);
      load_word(16'h0005);
      chk("fc_ovf5", ovf, 1);

      // full FIFO, load landing exactly on the tick edge
      sndon = 1'b0; nxt(2); sndon = 1'b1; nxt();
      load_word(16'h0011); load_word(16'h0022); load_word(16'h0033); load_word(16'h0044);
      n = 0;
      while (m_tcnt != 0 && n < 2000) begin nxt(); n++; end
      chk("sp_reach", 32'(m_tcnt == 0), 1);
      d = 16'h0055; sload_n = 1'b0; nxt(); sload_n = 1'b1;
      chk("sp_stb", stb, 1);
      chk("sp_word", {left, right}, 16'h0011);
      chk("sp_ovf", ovf, 0);
      chk("sp_sreq", sreq, 0);
      wait_stb("sp_d1", t0); chk("sp_w2", {left, right}, 16'h0022);
      wait_stb("sp_d2", t0); chk("sp_w3", {left, right}, 16'h0033);
      wait_stb("sp_d3", t0); chk("sp_w4", {left, right}, 16'h0044);
      wait_stb("sp_d4", t0); chk("sp_w5", {left, right}, 16'h0055);

      // underrun on the following tick
      nxt(700);
      chk("unf", unf, 1);
`ifdef SND_UNDERRUN_MUTE_EN
      chk("unf_lr", {left, right}, 16'h0000);
`else
      chk("unf_lr", {left, right}, 16'h0055);
`endif

      // randomized traffic
      lp = 3;
      for (int i = 0; i < 30000; i++) begin
         if (i % 4000 == 0) lp = ($urandom_range(0, 1) != 0) ? 3 : 400;
         if (!sload_n) begin
            if ($urandom_range(0, 3) != 0) sload_n = 1'b1;
         end else if ((sreq || $urandom_range(0, 15) == 0) && $urandom_range(0, lp) == 0) begin
            d = 16'($urandom);
            sload_n = 1'b0;
         end
         if (!sndon) begin
            if ($urandom_range(0, 3) == 0) sndon = 1'b1;
         end else if ($urandom_range(0, 2499) == 0) begin
            sndon = 1'b0;
         end
         if ($urandom_range(0, 1499) == 0) stereo = ~stereo;
         if ($urandom_range(0, 999) == 0) rate = 2'($urandom_range(2, 3));
         if ($urandom_range(0, 9999) == 0) begin
            por = 1'b1; nxt(); por = 1'b0;
         end
         nxt();
      end

      nxt(2);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/ste_snd_fifo.md
Name: ste_snd_fifo

Overview:
- Shifter-side receiver for the sound DMA stream that the MCU drives.
- Captures 16-bit RAM words on the MCU's sound load strobe (sload_n) and buffers them in a small FIFO.
- Plays the buffered bytes out as signed 8-bit left/right samples at the programmed sample rate.
- Drives sreq back to the MCU while there is room in the FIFO.

Parameters:
- DEPTH, 4, FIFO depth in 16-bit words (power of two, >=4).
- BASE_DIV, 640, clk32 cycles per sample at the fastest rate (50 kHz).

Ports:
- clk32  in  1  system clock; all logic is rising-edge on clk32.
- por  in  1  asynchronous reset, active-high.
- sndon  in  1  sound DMA enable from the control register; low flushes the block.
- sload_n  in  1  sound load strobe from the MCU, active-low; one word per low pulse.
- d  in  16  RAM data bus; valid while sload_n is low.
- stereo  in  1  1 = stereo (hi byte left, lo byte right); 0 = mono (hi byte, then lo byte).
- rate  in  2  sample rate select: 0 = 6.25 kHz, 1 = 12.5 kHz, 2 = 25 kHz, 3 = 50 kHz.
- sreq  out  1  request to the MCU for another word.
- left  out  8  signed left sample.
- right  out  8  signed right sample.
- stb  out  1  one-cycle pulse on each new sample.
- ovf  out  1  sticky flag: load arrived while the FIFO was full.
- unf  out  1  sticky flag: sample tick occurred with no data.

Behaviour:
- Reset (por high, asynchronous): FIFO empty, pointers 0, prescaler 0, mono phase 0, sload_n history 1; sreq=0, left=0, right=0, stb=0, ovf=0, unf=0.
- Load detect:
  - sload_n is registered once. A load fires in the cycle where the registered value is 1 and the current sload_n is 0 (falling edge).
  - d is captured in that same cycle.
  - Holding sload_n low produces exactly one load.
- Push: on load with sndon=1, if count<DEPTH, write d at wptr and increment wptr mod DEPTH. If count==DEPTH, drop the word and set ovf. Loads with sndon=0 are ignored.
- Prescaler:
  - Down-counter reloaded with (BASE_DIV<<(3-rate))-1; a tick is issued when it reaches 0.
  - rate is sampled only at reload, so a rate change applies from the next period.
  - The counter is held at reload value while sndon=0.
- Pop / output on each tick:
  - Stereo, FIFO non-empty: left=word[15:8], right=word[7:0]; pop the word.
  - Mono, FIFO non-empty: phase 0 drives word[15:8] to both channels and keeps the word; phase 1 drives word[7:0] to both channels and pops. Phase toggles after each tick.
  - stb pulses one cycle, registered together with left/right, in the cycle after the tick.
  - FIFO empty at tick: set unf, leave left/right unchanged, no stb, mono phase unchanged.
- Simultaneous push and pop in the same cycle: both happen and count is unchanged. A push into a full FIFO that is popped in the same cycle is accepted (pop is evaluated first).
- sreq:
  - Registered: sreq = sndon & (DEPTH-count >= 2).
  - Two free slots cover the one load already in flight between the MCU sampling sreq and issuing sload_n.
- sndon low (level):
  - Next cycle: FIFO flushed (pointers and count to 0), mono phase 0, sreq=0, left/right=0.
  - ovf and unf are cleared on the sndon rising edge only.
- Widths: count is log2(DEPTH)+1 bits. Pointers wrap mod DEPTH. Samples pass straight through, no sign conversion.
- stereo changing mid-stream: takes effect at the next tick; mono phase is forced to 0 when stereo=1.

Optional Feature:
- Macro: SND_UNDERRUN_MUTE_EN.
- Defined: on an underrun tick, left/right go to 0 and stb pulses, so the DAC sees silence.
- Undefined: on an underrun, left/right hold their last value and no stb is issued (as in Behaviour).
- unf is set in both builds.

Test Plan:
- Reset mid-stream: 3 words loaded, assert por for 1 cycle -> all outputs 0; sreq rises 1 cycle after por falls with sndon=1.
- Stereo, rate=3: load 0x7F80 -> on first tick left=0x7F, right=0x80, stb one cycle; ticks exactly 640 clk32 cycles apart.
- Mono, rate=0: load 0x1234 -> two samples 0x12/0x12 then 0x34/0x34, 5120 cycles apart; the word pops on the second tick.
- Flow control, DEPTH=4: load 3 words without ticks -> sreq drops after the 3rd load; 4th load accepted; 5th load dropped, ovf=1.
- Underrun: empty FIFO, sndon=1, wait one tick -> unf=1, outputs hold (or 0 with stb when SND_UNDERRUN_MUTE_EN is defined).
- Simultaneous push/pop: full FIFO, sload_n falling edge in the tick cycle -> count stays 4, no ovf, word order preserved.
